memory_read_ctrl: RTL and testbench
===================================

// Module: memory_read_ctrl
// PURPOSE
// Egress-side counterpart of the memory write controller. Takes a frame start block index from the
// arbiter and walks the frame's linked list of BLOCK_BITS-wide blocks in packet memory. Streams the
// payload out as 1-byte beats with begin/end markers, and returns each consumed block to the free list.
// PARAMETERS
// MAX_CHAIN_BLOCKS  32  runaway guard: max blocks followed per frame before forced termination
// (ADDR_W, BLOCK_BITS, PAYLOAD_BYTES (default 63), footer_t come from mem_pkg)
// PORTS
// clk               in   1           single clock
// rst               in   1           asynchronous, active-high reset
// start_valid_i     in   1           frame descriptor valid (from arb)
// start_addr_i      in   ADDR_W      first block index of frame
// start_ready_o     out  1           high only in IDLE
// mem_re_o          out  1           block read request
// mem_addr_o        out  ADDR_W      block index to read
// mem_ready_i       in   1           memory accepts request this cycle
// mem_rvalid_i      in   1           read data valid
// mem_rdata_i       in   BLOCK_BITS  {payload, footer_t}
// fl_free_req_o     out  1           return block to free list
// fl_free_idx_o     out  ADDR_W      block index being returned
// fl_free_gnt_i     in   1           free list accepted index
// data_o            out  8           egress byte
// data_valid_o      out  1           byte valid
// data_begin_o      out  1           first byte of frame (qualified by valid)
// data_end_o        out  1           last byte of frame (qualified by valid)
// data_ready_i      in   1           consumer accepts byte
// err_o             out  1           1-cycle pulse: chain truncated by MAX_CHAIN_BLOCKS
// BEHAVIOUR
// - Reset: all outputs 0 except start_ready_o=1 (state IDLE); counters, block_reg and cur_idx cleared.
// - Handshakes: transfer on valid&ready (start, data) / re&ready (mem) / req&gnt (free).
//   Requesters hold valid/req and payload stable until the transfer completes.
// - FSM: IDLE, RD_REQ, RD_WAIT, STREAM, FREE.
//   IDLE: start_ready_o=1; on start transfer latch cur_idx=start_addr_i, blk_cnt=0, first=1 -> RD_REQ.
//   RD_REQ: mem_re_o=1, mem_addr_o=cur_idx; on mem_ready_i -> RD_WAIT.
//   RD_WAIT: on mem_rvalid_i capture block_reg, blk_cnt+=1, byte_cnt=0 -> STREAM;
//     mem_rvalid_i in any other state is ignored.
//   STREAM: data_valid_o=1; data_o=payload byte byte_cnt (byte 0 = MSB byte, bits [BLOCK_BITS-1 -: 8]).
//     On accept, byte_cnt+=1. On accepting byte PAYLOAD_BYTES-1 -> FREE.
//   FREE: fl_free_req_o=1, fl_free_idx_o=cur_idx; on gnt: if last -> IDLE,
//     else cur_idx=footer.next_idx, first=0 -> RD_REQ.
// - last = footer.eop | (blk_cnt==MAX_CHAIN_BLOCKS); evaluated from captured block.
// - data_begin_o = valid & first & byte_cnt==0; data_end_o = valid & last & byte_cnt==PAYLOAD_BYTES-1.
//   1-block frame asserts both on distinct beats only.
// - Truncation (eop=0 at blk_cnt==MAX_CHAIN_BLOCKS): frame ends normally on that block's last byte.
//   err_o pulses the cycle of that block's free gnt; next_idx is not followed (tail leak accepted).
// - Every frame is whole blocks: exactly PAYLOAD_BYTES*blocks bytes; footer bits never emitted.
// - Backpressure: data_o/begin/end stable while valid & !ready; no drop/duplicate.
// - Latency: start accepted T -> mem_re_o T+1; first byte valid cycle after mem_rvalid_i;
//   FREE entered cycle after last-byte accept; next mem_re_o cycle after gnt.
// - No new frame accepted until FREE of last block completes (start_ready_o low).
// - blk_cnt width $clog2(MAX_CHAIN_BLOCKS+1); byte_cnt width $clog2(PAYLOAD_BYTES).
// - Reset mid-operation: immediate return to IDLE, outputs as reset, in-flight read data ignored,
//   unfreed blocks leak (accepted, same as writer-side policy).
// STRUCTURE
// - mem_pkg: reuse ADDR_W, BLOCK_BITS, PAYLOAD_BYTES, footer_t; add rd_state_t enum.
// - Single module; payload byte select as shift register (shift left 8 per accept), no sub-module.
// TESTING
// - 1-block frame idx 5, eop=1, payload 0x00..0x3E -> 63 beats, begin on 0x00, end on 0x3E, free 5,
//   start_ready_o high.
// - Chain 5->9->2 (eop on 2) -> 189 beats, one begin, one end, frees 5,9,2 in order, reads 5,9,2.
// - data_ready_i random 50% over 3-block frame -> byte sequence identical to no-stall run.
// - fl_free_gnt_i delayed 4 cycles -> fl_free_idx_o held, no mem_re_o until cycle after gnt.
// - mem_ready_i low 3 cycles, mem_rvalid_i 5 cycles late -> addr held, first beat cycle after rvalid.
// - Self-loop 7->7 eop=0, MAX_CHAIN_BLOCKS=4 -> 252 beats, end on beat 252, err_o one pulse.
//   Frees 7 ×4, then IDLE.
// - rst asserted mid-STREAM -> data_valid_o/fl_free_req_o/mem_re_o 0 immediately; new start accepted.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared packet-memory definitions for the write and read controllers.
//   ADDR_W        block index width
//   PAYLOAD_BYTES payload bytes per block
//   footer_t      per-block footer {eop, next_idx}, stored in the low bits of a block
//   BLOCK_BITS    full block width: {payload, footer_t}
//   rd_state_t    read controller FSM states
package mem_pkg;

    localparam int unsigned ADDR_W        = 7;
    localparam int unsigned PAYLOAD_BYTES = 63;

    typedef struct packed {
        logic              eop;
        logic [ADDR_W-1:0] next_idx;
    } footer_t;

    localparam int unsigned FOOTER_W   = $bits(footer_t);
    localparam int unsigned BLOCK_BITS = PAYLOAD_BYTES * 8 + FOOTER_W;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StStream,
        StFree
    } rd_state_t;

endpackage

// File: rtl/memory_read_ctrl.sv
// memory_read_ctrl: walks a frame's linked list of blocks in packet memory, streams the payload
// as byte beats with begin/end markers and returns each consumed block to the free list.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   start_valid_i/start_addr_i/_ready_o  frame descriptor from the arbiter
//   mem_re_o/mem_addr_o/mem_ready_i   block read request
//   mem_rvalid_i/mem_rdata_i          block read data {payload, footer_t}
//   fl_free_req_o/_idx_o/_gnt_i       block return to the free list
//   data_o/_valid_o/_begin_o/_end_o/data_ready_i  egress byte stream
//   err_o                             pulse: chain cut short by MAX_CHAIN_BLOCKS
module memory_read_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MAX_CHAIN_BLOCKS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid_i,
    input  logic [ADDR_W-1:0]     start_addr_i,
    output logic                  start_ready_o,
    output logic                  mem_re_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [BLOCK_BITS-1:0] mem_rdata_i,
    output logic                  fl_free_req_o,
    output logic [ADDR_W-1:0]     fl_free_idx_o,
    input  logic                  fl_free_gnt_i,
    output logic [7:0]            data_o,
    output logic                  data_valid_o,
    output logic                  data_begin_o,
    output logic                  data_end_o,
    input  logic                  data_ready_i,
    output logic                  err_o
);

    localparam int unsigned BlkW  = $clog2(MAX_CHAIN_BLOCKS + 1);
    localparam int unsigned ByteW = $clog2(PAYLOAD_BYTES);
    localparam int unsigned PayW  = PAYLOAD_BYTES * 8;

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cur_idx_q, cur_idx_d;
    logic [BlkW-1:0]   blk_cnt_q, blk_cnt_d;
    logic [ByteW-1:0]  byte_cnt_q, byte_cnt_d;
    logic              first_q, first_d;
    logic [PayW-1:0]   payload_q, payload_d;
    footer_t           footer_q, footer_d;
    logic              start_ready_q, start_ready_d;
    logic              mem_re_q, mem_re_d;
    logic              data_valid_q, data_valid_d;
    logic              fl_free_req_q, fl_free_req_d;

    logic cap_limit;
    logic last_blk;
    logic last_byte;

    // The chain limit only matters once the block that reaches it has been captured.
    assign cap_limit = (blk_cnt_q == BlkW'(MAX_CHAIN_BLOCKS));
    assign last_blk  = footer_q.eop | cap_limit;
    assign last_byte = (byte_cnt_q == ByteW'(PAYLOAD_BYTES - 1));

    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        blk_cnt_d  = blk_cnt_q;
        byte_cnt_d = byte_cnt_q;
        first_d    = first_q;
        payload_d  = payload_q;
        footer_d   = footer_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid_i) begin
                    cur_idx_d = start_addr_i;
                    blk_cnt_d = '0;
                    first_d   = 1'b1;
                    state_d   = StRdReq;
                end
            end
            StRdReq: begin
                if (mem_ready_i) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (mem_rvalid_i) begin
                    payload_d  = mem_rdata_i[BLOCK_BITS-1 -: PayW];
                    footer_d   = footer_t'(mem_rdata_i[FOOTER_W-1:0]);
                    blk_cnt_d  = blk_cnt_q + 1'b1;
                    byte_cnt_d = '0;
                    state_d    = StStream;
                end
            end
            StStream: begin
                if (data_ready_i) begin
                    // Current byte always sits in the top 8 bits of the shift register.
                    payload_d = payload_q << 8;
                    if (last_byte) begin
                        state_d = StFree;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            StFree: begin
                if (fl_free_gnt_i) begin
                    if (last_blk) begin
                        state_d = StIdle;
                    end else begin
                        cur_idx_d = footer_q.next_idx;
                        first_d   = 1'b0;
                        state_d   = StRdReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshake outputs are registered from the next state.
        start_ready_d = (state_d == StIdle);
        mem_re_d      = (state_d == StRdReq);
        data_valid_d  = (state_d == StStream);
        fl_free_req_d = (state_d == StFree);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cur_idx_q     <= '0;
            blk_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            first_q       <= 1'b0;
            payload_q     <= '0;
            footer_q      <= '0;
            start_ready_q <= 1'b1;
            mem_re_q      <= 1'b0;
            data_valid_q  <= 1'b0;
            fl_free_req_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_idx_q     <= cur_idx_d;
            blk_cnt_q     <= blk_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            first_q       <= first_d;
            payload_q     <= payload_d;
            footer_q      <= footer_d;
            start_ready_q <= start_ready_d;
            mem_re_q      <= mem_re_d;
            data_valid_q  <= data_valid_d;
            fl_free_req_q <= fl_free_req_d;
        end
    end

    assign start_ready_o = start_ready_q;
    assign mem_re_o      = mem_re_q;
    assign mem_addr_o    = cur_idx_q;
    assign fl_free_req_o = fl_free_req_q;
    assign fl_free_idx_o = cur_idx_q;
    assign data_o        = payload_q[PayW-1 -: 8];
    assign data_valid_o  = data_valid_q;
    assign data_begin_o  = data_valid_q & first_q & (byte_cnt_q == '0);
    assign data_end_o    = data_valid_q & last_blk & last_byte;
    // Truncated chain: flagged as the cut-off block is handed back.
    assign err_o         = fl_free_req_q & fl_free_gnt_i & ~footer_q.eop & cap_limit;

endmodule

// File: tb/tb_memory_read_ctrl.sv
// tb_memory_read_ctrl: directed and randomized frames against a linked-list reference model.
module tb_memory_read_ctrl;
    import mem_pkg::*;

    localparam int unsigned MaxChain = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start_valid_i;
    logic [ADDR_W-1:0]     start_addr_i;
    logic                  start_ready_o;
    logic                  mem_re_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic                  mem_ready_i;
    logic                  mem_rvalid_i;
    logic [BLOCK_BITS-1:0] mem_rdata_i;
    logic                  fl_free_req_o;
    logic [ADDR_W-1:0]     fl_free_idx_o;
    logic                  fl_free_gnt_i;
    logic [7:0]            data_o;
    logic                  data_valid_o;
    logic                  data_begin_o;
    logic                  data_end_o;
    logic                  data_ready_i;
    logic                  err_o;

    memory_read_ctrl #(.MAX_CHAIN_BLOCKS(MaxChain)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid_i (start_valid_i),
        .start_addr_i  (start_addr_i),
        .start_ready_o (start_ready_o),
        .mem_re_o      (mem_re_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ready_i   (mem_ready_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .fl_free_req_o (fl_free_req_o),
        .fl_free_idx_o (fl_free_idx_o),
        .fl_free_gnt_i (fl_free_gnt_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .data_begin_o  (data_begin_o),
        .data_end_o    (data_end_o),
        .data_ready_i  (data_ready_i),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Packet memory contents.
    bit                blk_eop  [128];
    logic [ADDR_W-1:0] blk_next [128];
    logic [7:0]        blk_pay  [128][PAYLOAD_BYTES];

    // Responder behaviour knobs.
    int cfg_mem_lat = 0;
    int cfg_rv_lat  = 0;
    int cfg_gnt_lat = 0;
    bit cfg_rand_ready = 0;

    // Observed transfers.
    logic [7:0]        beat_q[$];
    bit                beg_q[$];
    bit                end_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    logic [ADDR_W-1:0] fr_q[$];
    logic [7:0]        saved_q[$];
    int                err_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [BLOCK_BITS-1:0] block_word(input logic [ADDR_W-1:0] a);
        logic [BLOCK_BITS-1:0] w;
        w = '0;
        for (int b = 0; b < int'(PAYLOAD_BYTES); b++) w[BLOCK_BITS-1-8*b -: 8] = blk_pay[a][b];
        w[FOOTER_W-1:0] = {blk_eop[a], blk_next[a]};
        return w;
    endfunction

    // Memory / free-list / consumer responder and transfer monitor. Inputs change on the falling
    // edge; transfers are recorded #1 later, for the rising edge that follows.
    int                cyc = 0;
    bit                pend, rv_evt, gnt_evt, start_evt, stall_chk, re_hold, fr_hold;
    logic [ADDR_W-1:0] pend_addr, held_addr, held_fidx;
    int                rv_cnt, re_cnt, fr_cnt, rv_cyc, gnt_cyc, start_cyc;
    logic [7:0]        held_data;
    bit                held_beg, held_end;

    always begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            pend = 0; rv_evt = 0; gnt_evt = 0; start_evt = 0;
            stall_chk = 0; re_hold = 0; fr_hold = 0;
            re_cnt = 0; fr_cnt = 0; rv_cnt = 0;
            mem_ready_i = 0; mem_rvalid_i = 0; fl_free_gnt_i = 0; data_ready_i = 0;
            mem_rdata_i = '0;
        end else begin
            if (mem_re_o) begin
                mem_ready_i = (re_cnt >= cfg_mem_lat);
                re_cnt++;
            end else begin
                mem_ready_i = 0;
                re_cnt = 0;
            end
            mem_rvalid_i = 0;
            mem_rdata_i  = {16{$urandom()}};
            if (pend) begin
                if (rv_cnt >= cfg_rv_lat) begin
                    mem_rvalid_i = 1;
                    mem_rdata_i  = block_word(pend_addr);
                    pend   = 0;
                    rv_evt = 1;
                    rv_cyc = cyc;
                end else begin
                    rv_cnt++;
                end
            end
            data_ready_i = cfg_rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (fl_free_req_o) begin
                fl_free_gnt_i = (fr_cnt >= cfg_gnt_lat);
                fr_cnt++;
            end else begin
                fl_free_gnt_i = 0;
                fr_cnt = 0;
            end

            #1;
            if (start_valid_i && start_ready_o) begin
                start_evt = 1; start_cyc = cyc; gnt_evt = 0;
            end
            if (data_valid_o) begin
                if (rv_evt) begin
                    check("rvalid_to_beat", 64'(cyc), 64'(rv_cyc + 1));
                    rv_evt = 0;
                end
                if (stall_chk) begin
                    check("stall_data", data_o, held_data);
                    check("stall_flags", {data_begin_o, data_end_o}, {held_beg, held_end});
                end
                if (data_ready_i) begin
                    beat_q.push_back(data_o);
                    beg_q.push_back(data_begin_o);
                    end_q.push_back(data_end_o);
                    stall_chk = 0;
                end else begin
                    stall_chk = 1; held_data = data_o; held_beg = data_begin_o; held_end = data_end_o;
                end
            end else begin
                stall_chk = 0;
            end
            if (mem_re_o) begin
                if (start_evt) begin
                    check("start_to_re", 64'(cyc), 64'(start_cyc + 1));
                    start_evt = 0;
                end else if (gnt_evt) begin
                    check("gnt_to_re", 64'(cyc), 64'(gnt_cyc + 1));
                    gnt_evt = 0;
                end
                if (re_hold) check("re_addr_hold", mem_addr_o, held_addr);
                if (mem_ready_i) begin
                    rd_q.push_back(mem_addr_o);
                    pend = 1; pend_addr = mem_addr_o; rv_cnt = 0; re_hold = 0;
                end else begin
                    re_hold = 1; held_addr = mem_addr_o;
                end
            end
            if (fl_free_req_o) begin
                if (fr_hold) check("free_idx_hold", fl_free_idx_o, held_fidx);
                if (fl_free_gnt_i) begin
                    fr_q.push_back(fl_free_idx_o);
                    gnt_evt = 1; gnt_cyc = cyc; fr_hold = 0;
                end else begin
                    fr_hold = 1; held_fidx = fl_free_idx_o;
                end
            end
            if (err_o) err_seen++;
        end
    end

    // Starts a frame at `start`, waits for it to drain, and compares against the chain model.
    task automatic run_frame(input string tag, input logic [ADDR_W-1:0] start);
        logic [7:0]        exp_b[$];
        logic [ADDR_W-1:0] exp_i[$];
        logic [ADDR_W-1:0] idx;
        int                n, exp_err, mis, beg_n, end_n;
        bit                done;

        idx = start;
        n   = 0;
        forever begin
            exp_i.push_back(idx);
            n++;
            for (int b = 0; b < int'(PAYLOAD_BYTES); b++) exp_b.push_back(blk_pay[idx][b]);
            if (blk_eop[idx] || n == int'(MaxChain)) break;
            idx = blk_next[idx];
        end
        exp_err = blk_eop[idx] ? 0 : 1;

        beat_q.delete(); beg_q.delete(); end_q.delete(); rd_q.delete(); fr_q.delete();
        err_seen = 0;

        @(negedge clk);
        check({tag, "/start_ready"}, start_ready_o, 1'b1);
        start_addr_i  = start;
        start_valid_i = 1;
        @(negedge clk);
        start_valid_i = 0;
        start_addr_i  = ADDR_W'($urandom());

        done = 0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            #2;
            done = (fr_q.size() == exp_i.size()) && start_ready_o;
        end
        check({tag, "/done"}, done, 1'b1);

        check({tag, "/beats"}, beat_q.size(), exp_b.size());
        mis = 0;
        for (int i = 0; i < exp_b.size() && i < beat_q.size(); i++)
            if (beat_q[i] !== exp_b[i]) mis++;
        check({tag, "/byte_mismatches"}, mis, 0);

        beg_n = 0; end_n = 0;
        foreach (beg_q[i]) beg_n += int'(beg_q[i]);
        foreach (end_q[i]) end_n += int'(end_q[i]);
        check({tag, "/begin_count"}, beg_n, 1);
        check({tag, "/end_count"}, end_n, 1);
        if (beat_q.size() > 0) begin
            check({tag, "/begin_first"}, beg_q[0], 1'b1);
            check({tag, "/end_last"}, end_q[end_q.size()-1], 1'b1);
        end

        check({tag, "/frees"}, fr_q.size(), exp_i.size());
        check({tag, "/reads"}, rd_q.size(), exp_i.size());
        mis = 0;
        for (int i = 0; i < exp_i.size(); i++) begin
            if (i >= fr_q.size() || fr_q[i] !== exp_i[i]) mis++;
            if (i >= rd_q.size() || rd_q[i] !== exp_i[i]) mis++;
        end
        check({tag, "/idx_order"}, mis, 0);
        check({tag, "/err"}, err_seen, exp_err);
    endtask

    task automatic fill_random(input logic [ADDR_W-1:0] a, input bit eop, input logic [ADDR_W-1:0] nx);
        blk_eop[a]  = eop;
        blk_next[a] = nx;
        for (int b = 0; b < int'(PAYLOAD_BYTES); b++) blk_pay[a][b] = 8'($urandom());
    endtask

    initial begin
        int mis, len, base;
        logic [ADDR_W-1:0] ids[5];

        rst = 1; start_valid_i = 0; start_addr_i = '0;
        mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        fl_free_gnt_i = 0; data_ready_i = 0;
        for (int a = 0; a < 128; a++) fill_random(ADDR_W'(a), 1'b1, '0);

        repeat (3) @(negedge clk);
        #1;
        check("rst/start_ready", start_ready_o, 1'b1);
        check("rst/mem_re", mem_re_o, 1'b0);
        check("rst/data_valid", data_valid_o, 1'b0);
        check("rst/free_req", fl_free_req_o, 1'b0);
        check("rst/err", err_o, 1'b0);
        @(negedge clk);
        rst = 0;

        // Single-block frame with a counting payload.
        fill_random(5, 1'b1, 42);
        for (int b = 0; b < int'(PAYLOAD_BYTES); b++) blk_pay[5][b] = 8'(b);
        run_frame("one_blk", 5);
        if (beat_q.size() > 0) begin
            check("one_blk/first_byte", beat_q[0], 8'h00);
            check("one_blk/last_byte", beat_q[beat_q.size()-1], 8'h3e);
        end

        // Chain 5 -> 9 -> 2.
        fill_random(5, 1'b0, 9);
        fill_random(9, 1'b0, 2);
        fill_random(2, 1'b1, 100);
        run_frame("chain3", 5);
        saved_q = beat_q;

        // Same chain under random consumer backpressure.
        cfg_rand_ready = 1;
        run_frame("stall", 5);
        cfg_rand_ready = 0;
        mis = 0;
        foreach (saved_q[i]) if (i >= beat_q.size() || beat_q[i] !== saved_q[i]) mis++;
        check("stall/same_as_nostall", mis, 0);

        // Slow free-list grant.
        cfg_gnt_lat = 4;
        run_frame("gnt_lat", 5);
        cfg_gnt_lat = 0;

        // Slow memory accept and late read data.
        cfg_mem_lat = 3;
        cfg_rv_lat  = 5;
        run_frame("mem_lat", 5);
        cfg_mem_lat = 0;
        cfg_rv_lat  = 0;

        // Runaway self-loop, cut off by the chain limit.
        fill_random(7, 1'b0, 7);
        run_frame("self_loop", 7);
        check("self_loop/beats_252", beat_q.size(), 252);

        // Random chains, some longer than the limit, with random timing.
        for (int t = 0; t < 4; t++) begin
            len  = $urandom_range(1, 5);
            base = $urandom_range(0, 127);
            for (int k = 0; k < 5; k++) ids[k] = ADDR_W'(base + 11 * k);
            for (int k = 0; k < len; k++)
                fill_random(ids[k], (k == len - 1) && (len <= int'(MaxChain)),
                            (k < 4) ? ids[k+1] : ADDR_W'($urandom()));
            cfg_rand_ready = 1;
            cfg_mem_lat = $urandom_range(0, 2);
            cfg_rv_lat  = $urandom_range(0, 3);
            cfg_gnt_lat = $urandom_range(0, 3);
            run_frame("random", ids[0]);
        end
        cfg_rand_ready = 0; cfg_mem_lat = 0; cfg_rv_lat = 0; cfg_gnt_lat = 0;

        // Reset in the middle of streaming, then a fresh frame.
        @(negedge clk);
        start_addr_i  = 5;
        start_valid_i = 1;
        @(negedge clk);
        start_valid_i = 0;
        for (int c = 0; c < 100 && !data_valid_o; c++) @(negedge clk);
        check("rst_mid/streaming", data_valid_o, 1'b1);
        repeat (10) @(negedge clk);
        rst = 1;
        #1;
        check("rst_mid/data_valid", data_valid_o, 1'b0);
        check("rst_mid/free_req", fl_free_req_o, 1'b0);
        check("rst_mid/mem_re", mem_re_o, 1'b0);
        check("rst_mid/start_ready", start_ready_o, 1'b1);
        repeat (2) @(negedge clk);
        rst = 0;
        run_frame("after_rst", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
